// File: rtl/ternary_mv_engine.sv
// Ternary-weight matrix-vector engine: LOAD 2-bit weights, then stream vectors and drain OUT_LEN results.
// Latency: first result the cycle after a vector's last word, then OUT_LEN results back to back.
// Backpressure: none; words offered while draining are dropped. Define TERN_SAT_EN to saturate results.
module ternary_mv_engine #(
   parameter int IN_LEN  = 16,
   parameter int OUT_LEN = 8,
   parameter int DATA_W  = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [15:0]              in_data,
   input  logic                     in_valid,
   output logic signed [DATA_W-1:0] out_data,
   output logic                     out_valid,
   output logic                     busy
);
   localparam int ACC_W      = DATA_W + $clog2(IN_LEN) + 1;
   localparam int LOAD_WORDS = IN_LEN * OUT_LEN / 8;
   localparam int MULT_WORDS = IN_LEN / 2;
   localparam int ROW_W      = 2 * IN_LEN;
   localparam int WC_W       = (LOAD_WORDS > 1) ? $clog2(LOAD_WORDS) : 1;
   localparam int EC_W       = (MULT_WORDS > 1) ? $clog2(MULT_WORDS) : 1;
   localparam int IX_W       = (OUT_LEN > 1) ? $clog2(OUT_LEN) : 1;

   typedef enum logic [1:0] {IDLE, LOAD, MULT, DRAIN} state_t;
   state_t state, state_nxt;

   logic [WC_W-1:0]            word_cnt;
   logic [EC_W-1:0]            elem_cnt;
   logic [IX_W-1:0]            out_idx;
   logic [4:0]                 vec_left;
   logic [ROW_W*OUT_LEN-1:0]   wgt;
   logic [ROW_W-1:0]           wrow     [OUT_LEN];
   logic signed [ACC_W-1:0]    acc      [OUT_LEN];
   logic signed [ACC_W-1:0]    contrib  [OUT_LEN];
   logic signed [ACC_W-1:0]    acc_sel;
   logic signed [DATA_W-1:0]   result;
   logic                       load_last, mult_last, drain_last;

   assign load_last  = (word_cnt == WC_W'(LOAD_WORDS - 1));
   assign mult_last  = (elem_cnt == EC_W'(MULT_WORDS - 1));
   assign drain_last = (out_idx == IX_W'(OUT_LEN - 1));
   assign acc_sel    = acc[out_idx];

   // Ternary product: code 01 passes x, 11 negates it, anything else contributes zero.
   function automatic logic signed [ACC_W-1:0] tern(input logic [1:0] code, input logic signed [7:0] x);
      logic signed [ACC_W-1:0] xe;
      xe = ACC_W'(x);
      case (code)
         2'b01:   tern = xe;
         2'b11:   tern = -xe;
         default: tern = '0;
      endcase
   endfunction

   // Weights are written as a flat row-major image; view them per output row.
   always_comb begin
      for (int r = 0; r < OUT_LEN; r++) begin
         wrow[r] = wgt[ROW_W*r +: ROW_W];
      end
   end

   // Per-row contribution of the current word: two codes (4 bits) at column pair elem_cnt.
   always_comb begin
      logic [3:0] pair;
      pair = '0;
      for (int r = 0; r < OUT_LEN; r++) begin
         pair       = wrow[r][{elem_cnt, 2'b00} +: 4];
         contrib[r] = tern(pair[1:0], in_data[7:0]) + tern(pair[3:2], in_data[15:8]);
      end
   end

`ifdef TERN_SAT_EN
   localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (DATA_W - 1)) - 1);
   localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

   // Clamp the selected accumulator into the signed DATA_W range.
   always_comb begin
      if (acc_sel > SAT_MAX)      result = SAT_MAX[DATA_W-1:0];
      else if (acc_sel < SAT_MIN) result = SAT_MIN[DATA_W-1:0];
      else                        result = acc_sel[DATA_W-1:0];
   end
`else
   assign result = acc_sel[DATA_W-1:0];
`endif

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state: commands from IDLE, word counts end LOAD/MULT, DRAIN runs OUT_LEN cycles.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (in_valid) begin
               if (in_data[15:12] == 4'hA)      state_nxt = LOAD;
               else if (in_data[15:12] == 4'hF) state_nxt = MULT;
            end
         end
         LOAD:    if (in_valid && load_last) state_nxt = IDLE;
         MULT:    if (in_valid && mult_last) state_nxt = DRAIN;
         DRAIN:   if (drain_last) state_nxt = (vec_left != 5'd0) ? MULT : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs: results only while draining, zero otherwise.
   always_comb begin
      out_valid = (state == DRAIN);
      busy      = (state != IDLE);
      out_data  = (state == DRAIN) ? result : '0;
   end

   // Datapath: weight image, accumulators and the word/element/output counters.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         word_cnt <= '0;
         elem_cnt <= '0;
         out_idx  <= '0;
         vec_left <= '0;
         wgt      <= '0;
         for (int r = 0; r < OUT_LEN; r++) acc[r] <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  if (in_data[15:12] == 4'hA) begin
                     word_cnt <= '0;
                  end else if (in_data[15:12] == 4'hF) begin
                     vec_left <= {1'b0, in_data[3:0]} + 5'd1;
                     elem_cnt <= '0;
                  end
               end
            end
            LOAD: begin
               if (in_valid) begin
                  for (int w = 0; w < LOAD_WORDS; w++) begin
                     if (word_cnt == WC_W'(w)) wgt[16*w +: 16] <= in_data;
                  end
                  word_cnt <= load_last ? '0 : word_cnt + 1'b1;
               end
            end
            MULT: begin
               if (in_valid) begin
                  // First word of a vector restarts the sums instead of adding to stale ones.
                  for (int r = 0; r < OUT_LEN; r++) begin
                     acc[r] <= (elem_cnt == '0) ? contrib[r] : acc[r] + contrib[r];
                  end
                  if (mult_last) begin
                     elem_cnt <= '0;
                     out_idx  <= '0;
                     vec_left <= vec_left - 5'd1;
                  end else begin
                     elem_cnt <= elem_cnt + 1'b1;
                  end
               end
            end
            DRAIN: begin
               out_idx <= drain_last ? '0 : out_idx + 1'b1;
               if (drain_last) elem_cnt <= '0;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_ternary_mv_engine.sv
// Bench for ternary_mv_engine: random and directed LOAD/MULT traffic against a matrix-level model.
// Latency: expects the first result one cycle after the last vector word, OUT_LEN results in a row.
// Backpressure: none; junk words are driven during DRAIN and must be ignored.
module tb_ternary_mv_engine;
   localparam int IN_LEN     = 16;
   localparam int OUT_LEN    = 8;
   localparam int DATA_W     = 8;
   localparam int LOAD_WORDS = IN_LEN * OUT_LEN / 8;
   localparam int RAND       = 1000;

   logic                     clk = 1'b0;
   logic                     rst_n;
   logic [15:0]              in_data;
   logic                     in_valid;
   logic signed [DATA_W-1:0] out_data;
   logic                     out_valid;
   logic                     busy;

   ternary_mv_engine #(.IN_LEN(IN_LEN), .OUT_LEN(OUT_LEN), .DATA_W(DATA_W)) dut (
      .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
      .out_data(out_data), .out_valid(out_valid), .busy(busy)
   );

   always #5 clk = ~clk;

   int          n_vec = 0;
   int          n_bad = 0;
   int          wm [OUT_LEN][IN_LEN];
   int          xv [IN_LEN];
   int          exp_q [$];
   logic [15:0] load_buf [LOAD_WORDS];
   bit          lit_en;
   int          lit [OUT_LEN];

   task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
      end
   endtask

   function automatic int result_of(input int s);
`ifdef TERN_SAT_EN
      if (s > (2 ** (DATA_W - 1)) - 1) return (2 ** (DATA_W - 1)) - 1;
      if (s < -(2 ** (DATA_W - 1)))    return -(2 ** (DATA_W - 1));
      return s;
`else
      logic signed [DATA_W-1:0] t;
      t = DATA_W'(s);
      return int'(t);
`endif
   endfunction

   // Matrix-vector product of the model weights and the current vector.
   function automatic void push_expected();
      for (int r = 0; r < OUT_LEN; r++) begin
         int s;
         s = 0;
         for (int c = 0; c < IN_LEN; c++) s += wm[r][c] * xv[c];
         exp_q.push_back(result_of(s));
      end
   endfunction

   function automatic void clear_model();
      for (int r = 0; r < OUT_LEN; r++)
         for (int c = 0; c < IN_LEN; c++) wm[r][c] = 0;
   endfunction

   // Single compare process: every valid result against the model queue, zero data otherwise.
   always @(negedge clk) begin
      if (out_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL unexpected_out_valid: got out_data %0d with no result pending", out_data);
         end else begin
            check("out_data", out_data, exp_q.pop_front());
         end
      end else begin
         check("idle_out_data", out_data, 0);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [15:0] w);
      in_data  = w;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      in_data  = 16'($urandom);
   endtask

   task automatic gap_cycle();
      in_valid = 1'b0;
      in_data  = 16'($urandom);
      step();
   endtask

   function automatic bit want_gap(input int gap_mode);
      return (gap_mode == 1) || (gap_mode == 2 && $urandom_range(1, 0) == 1);
   endfunction

   task automatic do_load(input int gap_mode);
      send(16'hA000);
      for (int w = 0; w < LOAD_WORDS; w++) begin
         if (want_gap(gap_mode)) gap_cycle();
         send(load_buf[w]);
         for (int k = 0; k < 8; k++) begin
            int         idx;
            logic [1:0] code;
            idx  = w * 8 + k;
            code = load_buf[w][2*k +: 2];
            wm[idx / IN_LEN][idx % IN_LEN] = (code == 2'b01) ? 1 : (code == 2'b11) ? -1 : 0;
         end
      end
      @(negedge clk);
      check("busy_after_load", busy, 0);
   endtask

   task automatic run_mult(input int nvec, input int gap_mode, input int fill, input int rst_at);
      send({4'hF, 8'h00, 4'(nvec - 1)});
      for (int v = 0; v < nvec; v++) begin
         for (int i = 0; i < IN_LEN; i++)
            xv[i] = (fill == RAND) ? int'($urandom_range(255, 0)) - 128 : fill;
         for (int j = 0; j < IN_LEN / 2; j++) begin
            if (want_gap(gap_mode)) gap_cycle();
            send({8'(xv[2*j+1]), 8'(xv[2*j])});
         end
         push_expected();
         for (int c = 0; c < OUT_LEN; c++) begin
            in_valid = 1'($urandom_range(1, 0));
            in_data  = 16'($urandom);
            if (c == rst_at) rst_n = 1'b0;
            @(negedge clk);
            check("drain_valid", out_valid, 1);
            if (lit_en) check("literal_result", out_data, lit[c]);
            step();
            if (c == rst_at) begin
               in_valid = 1'b0;
               exp_q.delete();
               clear_model();
               @(negedge clk);
               check("valid_after_reset", out_valid, 0);
               check("busy_after_reset", busy, 0);
               step();
               rst_n = 1'b1;
               return;
            end
         end
         in_valid = 1'b0;
         @(negedge clk);
         check("busy_after_drain", busy, (v < nvec - 1) ? 1 : 0);
         check("valid_after_drain", out_valid, 0);
      end
      check("pending_results", exp_q.size(), 0);
   endtask

   initial begin
      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;
      lit_en   = 1'b0;
      clear_model();
      step();
      step();
      rst_n = 1'b1;

      // Idle after reset; non-command nibbles must not start anything.
      for (int i = 0; i < 5; i++) begin
         in_valid = (i >= 1);
         in_data  = {4'(i + 1), 12'(i * 37)};
         @(negedge clk);
         check("idle_busy", busy, 0);
         check("idle_valid", out_valid, 0);
         step();
      end
      in_valid = 1'b0;
      @(negedge clk);
      check("idle_busy_end", busy, 0);

      // All weights +1, all elements 1: every row sums to 16.
      for (int w = 0; w < LOAD_WORDS; w++) load_buf[w] = 16'h5555;
      do_load(0);
      lit_en = 1'b1;
      for (int c = 0; c < OUT_LEN; c++) lit[c] = 16;
      run_mult(1, 0, 1, -1);

      // Same weights, elements 100: 1600 saturates to 127 or wraps to 64.
      for (int c = 0; c < OUT_LEN; c++) begin
`ifdef TERN_SAT_EN
         lit[c] = 127;
`else
         lit[c] = 64;
`endif
      end
      run_mult(1, 0, 100, -1);

      // Row 0 all -1, other rows zero.
      for (int w = 0; w < LOAD_WORDS; w++) load_buf[w] = (w < 2) ? 16'hFFFF : 16'h0000;
      do_load(1);
      for (int c = 0; c < OUT_LEN; c++) lit[c] = (c == 0) ? -16 : 0;
      run_mult(1, 0, 1, -1);

      // Two vectors, words every other cycle, junk during DRAIN.
      lit_en = 1'b0;
      for (int w = 0; w < LOAD_WORDS; w++) load_buf[w] = 16'($urandom);
      do_load(2);
      run_mult(2, 1, RAND, -1);

      // Random weights and vectors, including the most negative element everywhere.
      for (int it = 0; it < 6; it++) begin
         for (int w = 0; w < LOAD_WORDS; w++) load_buf[w] = 16'($urandom);
         do_load(int'($urandom_range(2, 0)));
         run_mult(int'($urandom_range(3, 1)), int'($urandom_range(2, 0)), (it == 5) ? -128 : RAND, -1);
      end

      // Reset in the third DRAIN cycle, then weights must read back as zero.
      run_mult(1, 0, RAND, 2);
      lit_en = 1'b1;
      for (int c = 0; c < OUT_LEN; c++) lit[c] = 0;
      run_mult(1, 2, RAND, -1);

      repeat (3) step();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule

// File: doc/ternary_mv_engine.md
TERNARY_MV_ENGINE -- requirements
Module: ternary_mv_engine

Interface
REQ-001 Parameter IN_LEN, default 16, input vector length; even, at least 2.
REQ-002 Parameter OUT_LEN, default 8, output vector length; IN_LEN*OUT_LEN is a multiple of 8.
REQ-003 Parameter DATA_W, default 8, signed element and result width.
REQ-004 Port clk, input, 1, clock; all state changes on the rising edge.
REQ-005 Port rst_n, input, 1, reset; synchronous, active-low.
REQ-006 Port in_data, input, 16, command, weight or activation word.
REQ-007 Port in_valid, input, 1, in_data is offered this cycle.
REQ-008 Port out_data, output, DATA_W, signed result element.
REQ-009 Port out_valid, output, 1, out_data is valid this cycle.
REQ-010 Port busy, output, 1, high whenever state is not IDLE.

Function
REQ-011 States: IDLE, LOAD, MULT and DRAIN; a word is accepted on any edge where in_valid=1 and the state is IDLE, LOAD or MULT.
REQ-012 IDLE, accepted in_data[15:12]=4'hA -> LOAD with word counter cleared; 4'hF -> MULT with vec_left=in_data[3:0]+1 and element counter cleared; any other nibble is ignored.
REQ-013 LOAD word layout: 8 weights of 2 bits each, weight k in bits [2k+1:2k]; codes 01=+1, 11=-1, 00/10=0.
REQ-014 LOAD accepts IN_LEN*OUT_LEN/8 words in row-major order (row r = output r); state -> IDLE on the edge accepting the last word.
REQ-015 MULT word layout: element 2j in bits [7:0] and element 2j+1 in bits [15:8], both signed; IN_LEN/2 words make one vector.
REQ-016 Each accepted MULT word updates all OUT_LEN accumulators in parallel by w[r][2j]*x[2j] + w[r][2j+1]*x[2j+1].
REQ-017 The first word of a vector overwrites the accumulators with its contribution rather than adding to them.
REQ-018 Accumulator width is DATA_W+clog2(IN_LEN)+1, signed; accumulators never overflow.
REQ-019 On the edge accepting the last word of a vector: state -> DRAIN, out index set to 0, vec_left decremented.
REQ-020 DRAIN: out_valid=1 for exactly OUT_LEN consecutive cycles; out_data = result(acc[idx]), idx=0..OUT_LEN-1.
REQ-021 The first result is valid in the cycle immediately after the last word is accepted.
REQ-022 In DRAIN, in_valid is ignored and words are dropped; there is no backpressure.
REQ-023 After the final DRAIN cycle: state -> MULT with element counter cleared if vec_left != 0, otherwise -> IDLE.
REQ-024 out_valid=0 and out_data=0 whenever the state is not DRAIN.
REQ-025 Weights persist across MULT commands until the next LOAD completes or a reset occurs.
REQ-026 A partial LOAD leaves the unwritten weights at their previous values.
REQ-027 When in_valid=0 in LOAD or MULT, the machine holds its state and counters unchanged.

Reset
REQ-028 When rst_n=0 at an edge: state=IDLE, all counters=0, all accumulators=0, all weights=0, out_valid=0, out_data=0, busy=0.
REQ-029 A reset mid-LOAD, mid-MULT or mid-DRAIN aborts the operation; no further out_valid pulse occurs for the aborted vector.

Configuration
REQ-030 Macro TERN_SAT_EN defined: result = acc clamped to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
REQ-031 Macro TERN_SAT_EN undefined: result = acc[DATA_W-1:0], two's-complement wrap, with no clamp logic instantiated.

Verification
REQ-032 Reset, then idle for 5 cycles -> busy=0 and out_valid=0 throughout.
REQ-033 LOAD all weights +1 (16 words of 16'h5555), then MULT 16'hF000 with every element 1 -> 8 cycles of out_data=16 (0x10), then busy=0.
REQ-034 Same weights, all elements 100 -> out_data=127 with TERN_SAT_EN, out_data=0x40 (1600 mod 256) without.
REQ-035 Row 0 all -1 (16'hFFFF words) and all other rows 0, elements 1 -> out_data sequence -16, 0, 0, 0, 0, 0, 0, 0.
REQ-036 MULT 16'hF001 with two vectors and in_valid gapped every other cycle, plus extra words driven during DRAIN -> exactly 16 out_valid cycles, extra words ignored, correct sums.
REQ-037 rst_n=0 during the 3rd DRAIN cycle -> out_valid drops on the next cycle, weights read as 0 (a subsequent MULT yields all zeros).
